// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rf_pkg                                                           |
// | Brief   : Shared widths, FSM state encoding and helpers for the register-  |
// |           file writeback arbiter.                                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int STATS_W    = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + {{(STATS_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_pick                                                          |
// | Brief   : Combinational round-robin picker: first set bit of valid at or   |
// |           above ptr, wrapping around; one-hot result.                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rf_wb_arbiter                                                    |
// | Brief   : Round-robin arbiter sharing the register-file write port among  |
// |           NUM_REQ writeback sources, with capped grant locking.            |
// |           Optional statistics counters: define RF_WB_STATS_EN.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int LOCK_MAX = 4,
  parameter int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_wa,
  output logic [XLEN-1:0]               rf_wd,
  input  logic [REG_ADDR_W-1:0]         hz_addr,
  output logic                          hz_pending,
  input  logic [3:0]                    stats_sel,
  output logic [STATS_W-1:0]            stats_rdata
);

  localparam int               c_cnt_w    = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_lock_max = c_cnt_w'(LOCK_MAX);
  localparam logic [PTR_W-1:0] c_last     = PTR_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [c_cnt_w-1:0]     cnt_q, cnt_d;
  logic                   rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0]  rf_wa_q, rf_wa_d;
  logic [XLEN-1:0]        rf_wd_q, rf_wd_d;

  logic [REG_ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [XLEN-1:0]        data_arr [NUM_REQ];

  logic [NUM_REQ-1:0]     rr_grant;
  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W-1:0]       gidx;
  logic [PTR_W-1:0]       ptr_nxt;
  logic                   hs;
  logic                   owner_keep;
  logic [REG_ADDR_W-1:0]  sel_addr;
  logic [XLEN-1:0]        sel_data;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
    assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
  end

  // While LOCKED the pointer already sits at owner+1, so on lock exit the
  // plain picker output is exactly the round-robin from owner+1.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (rr_grant)
  );

  always_comb begin
    owner_keep = (state_q == ST_LOCKED) && req_valid[owner_q] &&
                 req_lock[owner_q] && (cnt_q < c_lock_max);
    grant = '0;
    if (rst_n && !stall) begin
      if (owner_keep) begin
        grant[owner_q] = 1'b1;
      end else begin
        grant = rr_grant;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx = PTR_W'(i);
      end
    end
  end

  assign hs       = |grant;
  assign sel_addr = addr_arr[gidx];
  assign sel_data = data_arr[gidx];
  assign ptr_nxt  = (gidx == c_last) ? '0 : gidx + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    // Stall freezes the FSM so stalled cycles never consume lock budget.
    if (!stall) begin
      if (owner_keep) begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (hs && req_lock[gidx]) begin
          state_d = ST_LOCKED;
          owner_d = gidx;
          cnt_d   = c_cnt_w'(1);
        end
      end
      if (hs) begin
        ptr_d   = ptr_nxt;
        rf_we_d = (sel_addr != '0);
        rf_wa_d = sel_addr;
        rf_wd_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign req_ready  = grant;
  assign rf_we      = rf_we_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;
  assign hz_pending = rf_we_q && (rf_wa_q == hz_addr) && (hz_addr != '0);

`ifdef RF_WB_STATS_EN
  logic [STATS_W-1:0] gcnt_q [NUM_REQ];
  logic [STATS_W-1:0] gcnt_d [NUM_REQ];
  logic [STATS_W-1:0] x0cnt_q, x0cnt_d;
  logic [STATS_W-1:0] rotcnt_q, rotcnt_d;
  logic               forced_rot;

  // An owner still asking for the port when its budget is spent is a forced rotation.
  assign forced_rot = (state_q == ST_LOCKED) && !stall && req_valid[owner_q] &&
                      req_lock[owner_q] && (cnt_q == c_lock_max);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gcnt_d[i] = grant[i] ? sat_inc(gcnt_q[i]) : gcnt_q[i];
    end
    x0cnt_d  = (hs && (sel_addr == '0)) ? sat_inc(x0cnt_q) : x0cnt_q;
    rotcnt_d = forced_rot ? sat_inc(rotcnt_q) : rotcnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= '0;
      end
      x0cnt_q  <= '0;
      rotcnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= gcnt_d[i];
      end
      x0cnt_q  <= x0cnt_d;
      rotcnt_q <= rotcnt_d;
    end
  end

  always_comb begin
    stats_rdata = '0;
    if (stats_sel == 4'd14) begin
      stats_rdata = x0cnt_q;
    end else if (stats_sel == 4'd15) begin
      stats_rdata = rotcnt_q;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_sel == 4'(i)) begin
          stats_rdata = gcnt_q[i];
        end
      end
    end
  end
`else
  logic unused_stats_sel;
  assign unused_stats_sel = ^stats_sel;
  assign stats_rdata      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_rf_wb_arbiter                                                 |
// | Brief   : Directed scoreboard bench for rf_wb_arbiter (3 requesters,       |
// |           LOCK_MAX=4); stats expectations follow RF_WB_STATS_EN.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_rf_wb_arbiter;

`ifdef RF_WB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hz;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [2:0]  req_valid;
  logic [2:0]  req_lock;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  hz_addr;
  logic        hz_pending;
  logic [3:0]  stats_sel;
  logic [15:0] stats_rdata;

  logic [4:0]  a [3];
  logic [31:0] d [3];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  always_comb begin
    req_addr = {a[2], a[1], a[0]};
    req_data = {d[2], d[1], d[0]};
  end

  rf_wb_arbiter #(
    .NUM_REQ  (3),
    .LOCK_MAX (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .hz_addr     (hz_addr),
    .hz_pending  (hz_pending),
    .stats_sel   (stats_sel),
    .stats_rdata (stats_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Monitor: expectations were queued when the cycle's stimulus was issued.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (req_ready !== e.rdy) begin
        errors++;
        $display("FAIL ready step %0d: got %b want %b", e.id, req_ready, e.rdy);
      end
      checks++;
      if (rf_we !== e.we) begin
        errors++;
        $display("FAIL rf_we step %0d: got %b want %b", e.id, rf_we, e.we);
      end
      if (e.we) begin
        checks++;
        if (rf_wa !== e.wa || rf_wd !== e.wd) begin
          errors++;
          $display("FAIL rf_wa/wd step %0d: got %0d/%h want %0d/%h", e.id, rf_wa, rf_wd, e.wa, e.wd);
        end
      end
      checks++;
      if (hz_pending !== e.hz) begin
        errors++;
        $display("FAIL hz_pending step %0d: got %b want %b", e.id, hz_pending, e.hz);
      end
    end
  end

  task automatic step(input logic [2:0] v, input logic [2:0] l, input logic st,
                      input logic [4:0] hz, input logic [2:0] e_rdy, input logic e_we,
                      input logic [4:0] e_wa, input logic [31:0] e_wd, input logic e_hz);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    req_lock  = l;
    stall     = st;
    hz_addr   = hz;
    step_id++;
    e.id  = step_id;
    e.rdy = e_rdy;
    e.we  = e_we;
    e.wa  = e_wa;
    e.wd  = e_wd;
    e.hz  = e_hz;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input logic [47:0] got, input logic [47:0] want, input string nm);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check_stat(input logic [3:0] sel, input logic [15:0] want, input string nm);
    stats_sel = sel;
    #1;
    check_now({32'd0, stats_rdata}, {32'd0, want}, nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_lock  = 3'b000;
    hz_addr   = 5'd0;
    stats_sel = 4'd0;
    a[0] = 5'd5; d[0] = 32'hAAAA5555;
    a[1] = 5'd6; d[1] = 32'h11111111;
    a[2] = 5'd7; d[2] = 32'h22222222;

    // Reset state
    #3;
    check_now({45'd0, req_ready}, 48'd0, "reset ready");
    check_now({10'd0, rf_we, rf_wa, rf_wd}, 48'd0, "reset rf outputs");
    check_now({47'd0, hz_pending}, 48'd0, "reset hz_pending");
    check_stat(4'd0, 16'd0, "reset stats");
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 3'b000;

    // Fairness: grants 0,1,2,0,1,2 from pointer 0
    step(3'b111, 3'b000, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b111, 3'b000, 1'b0, 5'd0, 3'b010, 1'b1, 5'd5, 32'hAAAA5555, 1'b0);
    step(3'b111, 3'b000, 1'b0, 5'd0, 3'b100, 1'b1, 5'd6, 32'h11111111, 1'b0);
    step(3'b111, 3'b000, 1'b0, 5'd0, 3'b001, 1'b1, 5'd7, 32'h22222222, 1'b0);
    step(3'b111, 3'b000, 1'b0, 5'd0, 3'b010, 1'b1, 5'd5, 32'hAAAA5555, 1'b0);
    step(3'b111, 3'b000, 1'b0, 5'd0, 3'b100, 1'b1, 5'd6, 32'h11111111, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b1, 5'd7, 32'h22222222, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);

    // Single write, one-cycle latency, pointer back at 0
    step(3'b001, 3'b000, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b1, 5'd5, 32'hAAAA5555, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);

    // Lock cap: pointer=1, req1 locks four times, then forced rotation to req2
    step(3'b111, 3'b010, 1'b0, 5'd0, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b111, 3'b010, 1'b0, 5'd0, 3'b010, 1'b1, 5'd6, 32'h11111111, 1'b0);
    step(3'b111, 3'b010, 1'b0, 5'd0, 3'b010, 1'b1, 5'd6, 32'h11111111, 1'b0);
    step(3'b111, 3'b010, 1'b0, 5'd0, 3'b010, 1'b1, 5'd6, 32'h11111111, 1'b0);
    step(3'b111, 3'b010, 1'b0, 5'd0, 3'b100, 1'b1, 5'd6, 32'h11111111, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b1, 5'd7, 32'h22222222, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);

    // x0 gating: handshake happens, write suppressed
    a[2] = 5'd0; d[2] = 32'hDEADBEEF;
    step(3'b100, 3'b000, 1'b0, 5'd0, 3'b100, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);
    drain();
    a[2] = 5'd7; d[2] = 32'h22222222;

    // Stall and hazard on r12
    a[0] = 5'd12; d[0] = 32'h0C0C0C0C;
    step(3'b001, 3'b000, 1'b1, 5'd12, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b001, 3'b000, 1'b1, 5'd12, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b001, 3'b000, 1'b1, 5'd12, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b001, 3'b000, 1'b0, 5'd12, 3'b001, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd12, 3'b000, 1'b1, 5'd12, 32'h0C0C0C0C, 1'b1);
    step(3'b000, 3'b000, 1'b0, 5'd12, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);
    drain();
    a[0] = 5'd5; d[0] = 32'hAAAA5555;
    hz_addr = 5'd0;

    // Statistics (zero when the counters are not built)
    @(negedge clk);
    check_stat(4'd0,  STATS ? 16'd4 : 16'd0, "stat grant0");
    check_stat(4'd1,  STATS ? 16'd6 : 16'd0, "stat grant1");
    check_stat(4'd2,  STATS ? 16'd4 : 16'd0, "stat grant2");
    check_stat(4'd14, STATS ? 16'd1 : 16'd0, "stat x0 drops");
    check_stat(4'd15, STATS ? 16'd1 : 16'd0, "stat forced rotations");
    stats_sel = 4'd5;
    #1;
    check_now({32'd0, stats_rdata}, 48'd0, "stat unmapped select");

    // Reset mid-lock: pointer is 1, req1 locks and writes
    step(3'b010, 3'b010, 1'b0, 5'd0, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b010, 3'b010, 1'b0, 5'd0, 3'b010, 1'b1, 5'd6, 32'h11111111, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now({47'd0, rf_we}, 48'd0, "mid-lock reset rf_we");
    check_now({45'd0, req_ready}, 48'd0, "mid-lock reset ready");
    req_valid = 3'b000;
    req_lock  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b111, 3'b000, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 32'h0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b1, 5'd5, 32'hAAAA5555, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
